// File: rtl/typing_game_core_pkg.sv
// Shared types for the typing game: game phase enum and digit width.
package typing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } game_state_t;

  localparam int DIGIT_W = 4;

endpackage

// File: rtl/typing_game_core_countdown_timer.sv
// Loadable down-counter for the game clock; holds at zero.
module countdown_timer #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         expired
);

  // Combinational so the parent can change phase on the same edge the count reaches zero.
  assign expired = en && tick && !load && (count == W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= RESET_VAL;
    else if (load)
      count <= load_val;
    else if (en && tick && (count != '0))
      count <= count - 1'b1;
  end

endmodule

// File: rtl/typing_game_core.sv
// Typing game: random hex target word, keypad matching under a countdown, score display at end.
module typing_game_core
  import typing_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TIME_LIMIT_S = 30,
  parameter int SCORE_W      = 8,
  parameter int STRICT       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick_1hz,
  input  logic                          key_valid,
  input  logic [DIGIT_W-1:0]            key_code,
  input  logic                          start,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] rand_digits,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digit_out,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic [7:0]                    time_left,
  output logic [SCORE_W-1:0]            score,
  output logic [SCORE_W-1:0]            mistakes,
  output logic                          game_over
);

  localparam int         DW = DIGIT_W * NUM_DIGITS;
  localparam int         CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int         IW = $clog2(DW);
  localparam logic [7:0] TL = 8'(TIME_LIMIT_S);

  game_state_t          state;
  logic [DW-1:0]        target;
  logic [CW-1:0]        cursor;
  logic [CW-1:0]        rev;
  logic [IW-1:0]        sel_lo;
  logic [DIGIT_W-1:0]   cur_digit;
  logic                 playing;
  logic                 hit;
  logic                 miss;
  logic                 last;
  logic                 word_done;
  logic                 expired;
  logic [SCORE_W-1:0]   score_nxt;
  logic [DW-1:0]        score_disp;

  // Digit 0 lives in the MSBs, so cursor position n maps to nibble (NUM_DIGITS-1-n).
  assign rev       = CW'(NUM_DIGITS - 1) - cursor;
  assign sel_lo    = IW'(rev) * IW'(DIGIT_W);
  assign cur_digit = target[sel_lo +: DIGIT_W];

  assign playing   = (state == PLAY) && !start;
  assign hit       = playing && key_valid && (key_code == cur_digit);
  assign miss      = playing && key_valid && (key_code != cur_digit);
  assign last      = (cursor == CW'(NUM_DIGITS - 1));
  assign word_done = hit && last;
  assign score_nxt = (word_done && (score != '1)) ? score + 1'b1 : score;

  generate
    if (SCORE_W >= DW) begin : g_disp_trunc
      assign score_disp = score_nxt[DW-1:0];
    end else begin : g_disp_ext
      assign score_disp = {{(DW - SCORE_W){1'b0}}, score_nxt};
    end
  endgenerate

  countdown_timer #(
    .W        (8),
    .RESET_VAL(TL)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start),
    .load_val(TL),
    .tick    (tick_1hz),
    .en      (state == PLAY),
    .count   (time_left),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      target    <= '0;
      cursor    <= '0;
      digit_out <= '0;
      digit_en  <= '1;
      score     <= '0;
      mistakes  <= '0;
      game_over <= 1'b0;
    end else if (start) begin
      // Restart from any phase; a coincident key or tick is dropped.
      state     <= PLAY;
      target    <= rand_digits;
      cursor    <= '0;
      digit_out <= rand_digits;
      digit_en  <= '1;
      score     <= '0;
      mistakes  <= '0;
      game_over <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          score <= score_nxt;
          if (hit) begin
            if (last) begin
              target    <= rand_digits;
              digit_out <= rand_digits;
              cursor    <= '0;
              digit_en  <= '1;
            end else begin
              digit_en[rev] <= 1'b0;
              cursor        <= cursor + 1'b1;
            end
          end
          if (miss) begin
            if (mistakes != '1)
              mistakes <= mistakes + 1'b1;
            if (STRICT != 0) begin
              cursor   <= '0;
              digit_en <= '1;
            end
          end
          // A key in the final-tick cycle is already folded into score_nxt.
          if (expired) begin
            state     <= DONE;
            game_over <= 1'b1;
            digit_out <= score_disp;
            digit_en  <= '1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
